decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder.sv | 69 ++++++
 tb/tb_decoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder.sv
// 3-to-8 line decoder with enable, valid flag, optional output register
// and optional active-low output polarity.
module decoder #(
  parameter bit REGISTER_OUT   = 1'b1,
  parameter bit ACTIVE_LOW_OUT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic x,
  input  logic y,
  input  logic z,
  input  logic en,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic valid
);

  logic [2:0] sel;
  logic [7:0] line_d;
  logic       valid_d;
  logic [7:0] line_r;
  logic       valid_r;
  logic [7:0] dbus;

  assign sel = {x, y, z};

  always_comb begin
    line_d  = '0;
    valid_d = 1'b0;
    if (en) begin
      line_d[sel] = 1'b1;
      valid_d     = 1'b1;
    end
  end

  if (REGISTER_OUT) begin : g_reg
    logic [7:0] line_q;
    logic       valid_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        line_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        line_q  <= line_d;
        valid_q <= valid_d;
      end
    end

    assign line_r  = line_q;
    assign valid_r = valid_q;
  end else begin : g_comb
    // Reset still gates the combinational path so all lines read idle.
    assign line_r  = rst ? line_d : '0;
    assign valid_r = rst & valid_d;
  end

  assign dbus  = ACTIVE_LOW_OUT ? ~line_r : line_r;
  assign valid = valid_r;

  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dbus;

endmodule

// File: tb/tb_decoder.sv
// Directed self-checking bench for decoder: registered, active-low
// and combinational variants driven from shared inputs.
module tb_decoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x = 1'b0, y = 1'b0, z = 1'b0, en = 1'b0;

  logic r0, r1, r2, r3, r4, r5, r6, r7, rv;
  logic l0, l1, l2, l3, l4, l5, l6, l7, lv;
  logic c0, c1, c2, c3, c4, c5, c6, c7, cv;
  logic [7:0] dr, dl, dc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decoder u_reg (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en),
    .d0(r0), .d1(r1), .d2(r2), .d3(r3),
    .d4(r4), .d5(r5), .d6(r6), .d7(r7), .valid(rv)
  );

  decoder #(.REGISTER_OUT(1'b1), .ACTIVE_LOW_OUT(1'b1)) u_low (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en),
    .d0(l0), .d1(l1), .d2(l2), .d3(l3),
    .d4(l4), .d5(l5), .d6(l6), .d7(l7), .valid(lv)
  );

  decoder #(.REGISTER_OUT(1'b0), .ACTIVE_LOW_OUT(1'b0)) u_comb (
    .clk(clk), .rst(rst), .x(x), .y(y), .z(z), .en(en),
    .d0(c0), .d1(c1), .d2(c2), .d3(c3),
    .d4(c4), .d5(c5), .d6(c6), .d7(c7), .valid(cv)
  );

  assign dr = {r7, r6, r5, r4, r3, r2, r1, r0};
  assign dl = {l7, l6, l5, l4, l3, l2, l1, l0};
  assign dc = {c7, c6, c5, c4, c3, c2, c1, c0};

  task automatic set_sel(input int s);
    x = s[2];
    y = s[1];
    z = s[0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #2;
    rst = 1'b0;
    set_sel(7);
    en = 1'b1;
    #1;
    checks++;
    if (dr !== 8'h00) begin
      errors++;
      $display("FAIL reset_reg_d got %h exp %h", dr, 8'h00);
    end
    checks++;
    if (rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_reg_valid got %b exp 0", rv);
    end
    checks++;
    if (dl !== 8'hFF || lv !== 1'b0) begin
      errors++;
      $display("FAIL reset_low got %h/%b exp ff/0", dl, lv);
    end
    checks++;
    if (dc !== 8'h00 || cv !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb got %h/%b exp 00/0", dc, cv);
    end
    tick();
    checks++;
    if (dr !== 8'h00 || rv !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got %h/%b exp 00/0", dr, rv);
    end
    rst = 1'b1;
  endtask

  task automatic test_sweep;
    logic [7:0] exp_v;
    logic [7:0] prev;
    set_sel(0);
    en = 1'b1;
    tick();
    prev = 8'h01;
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      exp_v = 8'h01 << s;
      #1;
      checks++;
      if (dc !== exp_v || cv !== 1'b1) begin
        errors++;
        $display("FAIL sweep_comb s=%0d got %h/%b exp %h/1",
                 s, dc, cv, exp_v);
      end
      checks++;
      if (dr !== prev) begin
        errors++;
        $display("FAIL sweep_latency s=%0d got %h exp %h",
                 s, dr, prev);
      end
      tick();
      checks++;
      if (dr !== exp_v || rv !== 1'b1) begin
        errors++;
        $display("FAIL sweep_reg s=%0d got %h/%b exp %h/1",
                 s, dr, rv, exp_v);
      end
      prev = exp_v;
    end
  endtask

  task automatic test_enable;
    en = 1'b0;
    set_sel(3);
    #1;
    checks++;
    if (dc !== 8'h00 || cv !== 1'b0) begin
      errors++;
      $display("FAIL enable_comb_off got %h/%b exp 00/0", dc, cv);
    end
    tick();
    checks++;
    if (dr !== 8'h00 || rv !== 1'b0) begin
      errors++;
      $display("FAIL enable_off got %h/%b exp 00/0", dr, rv);
    end
    for (int s = 0; s < 8; s += 3) begin
      set_sel(s);
      tick();
      checks++;
      if (dr !== 8'h00 || rv !== 1'b0) begin
        errors++;
        $display("FAIL enable_off_sel s=%0d got %h/%b exp 00/0",
                 s, dr, rv);
      end
    end
    set_sel(3);
    en = 1'b1;
    tick();
    checks++;
    if (dr !== 8'h08 || rv !== 1'b1) begin
      errors++;
      $display("FAIL enable_on got %h/%b exp 08/1", dr, rv);
    end
  endtask

  task automatic test_mid_reset;
    set_sel(6);
    en = 1'b1;
    tick();
    checks++;
    if (dr !== 8'h40 || rv !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got %h/%b exp 40/1", dr, rv);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dr !== 8'h00 || rv !== 1'b0) begin
      errors++;
      $display("FAIL midrst_clear got %h/%b exp 00/0", dr, rv);
    end
    checks++;
    if (dl !== 8'hFF || dc !== 8'h00) begin
      errors++;
      $display("FAIL midrst_others got %h/%h exp ff/00", dl, dc);
    end
    set_sel(5);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dr !== 8'h00 || rv !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release got %h/%b exp 00/0", dr, rv);
    end
    tick();
    checks++;
    if (dr !== 8'h20 || rv !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reload got %h/%b exp 20/1", dr, rv);
    end
  endtask

  task automatic test_active_low;
    set_sel(2);
    en = 1'b1;
    tick();
    checks++;
    if (dl !== 8'hFB || lv !== 1'b1) begin
      errors++;
      $display("FAIL active_low got %h/%b exp fb/1", dl, lv);
    end
    en = 1'b0;
    tick();
    checks++;
    if (dl !== 8'hFF || lv !== 1'b0) begin
      errors++;
      $display("FAIL active_low_off got %h/%b exp ff/0", dl, lv);
    end
  endtask

  task automatic test_comb;
    en = 1'b1;
    set_sel(4);
    #1;
    checks++;
    if (dc !== 8'h10 || cv !== 1'b1) begin
      errors++;
      $display("FAIL comb_s4 got %h/%b exp 10/1", dc, cv);
    end
    set_sel(1);
    #1;
    checks++;
    if (dc !== 8'h02 || cv !== 1'b1) begin
      errors++;
      $display("FAIL comb_s1 got %h/%b exp 02/1", dc, cv);
    end
    checks++;
    if (dr !== 8'h00) begin
      errors++;
      $display("FAIL comb_reg_hold got %h exp 00", dr);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_enable();
    test_mid_reset();
    test_active_low();
    test_comb();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
